// File: rtl/conv_pkg.sv
// Shared constants for the convolution datapath: frame geometry and the
// 2-bit loader state encoding used on the state buses between stages.
package conv_pkg;

    localparam int unsigned PIX_W       = 8;
    localparam int unsigned DATA_DIM    = 4;
    localparam int unsigned FILT_DIM    = 3;
    localparam int unsigned FILT_BYTES  = FILT_DIM * FILT_DIM;
    localparam int unsigned DATA_BYTES  = DATA_DIM * DATA_DIM;
    localparam int unsigned FRAME_BYTES = FILT_BYTES + DATA_BYTES;
    localparam int unsigned IDX_W       = 5;
    localparam int unsigned FILT_W      = FILT_BYTES * PIX_W;
    localparam int unsigned DATA_W      = DATA_BYTES * PIX_W;

    // Loader state encoding
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LOAD_FILT = 2'd1;
    localparam logic [1:0] S_LOAD_DATA = 2'd2;
    localparam logic [1:0] S_FULL      = 2'd3;

endpackage

// File: rtl/conv_frame_shadow.sv
// Shadow frame buffer: FRAME_BYTES x PIX_W byte-addressed register file.
// Indices 0..FILT_BYTES-1 hold the filter, the rest hold the data tile.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears all bytes)
//   we, idx   : write enable and byte index
//   wdata     : byte to write
//   filt      : flat filter view, byte k at [8k+7:8k]
//   data      : flat data-tile view, byte k at [8k+7:8k]
module conv_frame_shadow
    import conv_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [IDX_W-1:0]    idx,
    input  logic [PIX_W-1:0]    wdata,
    output logic [FILT_W-1:0]   filt,
    output logic [DATA_W-1:0]   data
);

    logic [PIX_W-1:0] mem [FRAME_BYTES];

    // Byte write port; out-of-range indices are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(FRAME_BYTES); i++) begin
                mem[i] <= '0;
            end
        end else if (we && (idx < IDX_W'(FRAME_BYTES))) begin
            mem[idx] <= wdata;
        end
    end

    // Flat views of the two regions
    for (genvar g = 0; g < int'(FILT_BYTES); g++) begin : g_filt
        assign filt[g*PIX_W +: PIX_W] = mem[g];
    end

    for (genvar g = 0; g < int'(DATA_BYTES); g++) begin : g_data
        assign data[g*PIX_W +: PIX_W] = mem[FILT_BYTES + g];
    end

endmodule

// File: rtl/conv_input_loader.sv
// Input loader: assembles a 3x3 filter followed by a 4x4 data tile from a
// valid/ready byte stream into a shadow buffer, then commits the whole frame
// atomically to DATA/FILTER under a frame_valid/frame_ack handshake.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   in_data      : stream byte
//   in_valid     : in_data valid
//   in_ready     : loader accepts a byte this cycle
//   abort        : discard the partially loaded frame
//   frame_ack    : controller has consumed the committed frame
//   frame_valid  : DATA/FILTER hold an unacknowledged frame
//   DATA, FILTER : committed frame, byte k at [8k+7:8k], row-major
//   busy         : shadow buffer partially or fully loaded
module conv_input_loader
    import conv_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [PIX_W-1:0]    in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                abort,
    input  logic                frame_ack,
    output logic                frame_valid,
    output logic [DATA_W-1:0]   DATA,
    output logic [FILT_W-1:0]   FILTER,
    output logic                busy
);

    logic [1:0]        state;
    logic [IDX_W-1:0]  byte_cnt;
    logic              xfer;
    logic              commit;
    logic              last_filt;
    logic              last_byte;
    logic [FILT_W-1:0] shadow_filt;
    logic [DATA_W-1:0] shadow_data;

    // Handshake is a function of registered state and abort only
    assign in_ready  = (state != S_FULL) & ~abort;
    assign busy      = (state != S_IDLE);
    assign xfer      = in_valid & in_ready;
    // abort suppresses a same-cycle commit
    assign commit    = (state == S_FULL) & (~frame_valid | frame_ack) & ~abort;
    assign last_filt = (byte_cnt == IDX_W'(FILT_BYTES - 1));
    assign last_byte = (byte_cnt == IDX_W'(FRAME_BYTES - 1));

    conv_frame_shadow u_shadow (
        .clk   (clk),
        .rst   (rst),
        .we    (xfer),
        .idx   (byte_cnt),
        .wdata (in_data),
        .filt  (shadow_filt),
        .data  (shadow_data)
    );

    // Loader FSM and byte counter; counter parks at the last index while full
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            byte_cnt <= '0;
        end else if (abort || commit) begin
            state    <= S_IDLE;
            byte_cnt <= '0;
        end else if (xfer) begin
            case (state)
                S_IDLE:      state <= S_LOAD_FILT;
                S_LOAD_FILT: if (last_filt) state <= S_LOAD_DATA;
                S_LOAD_DATA: if (last_byte) state <= S_FULL;
                default:     state <= state;
            endcase
            if (!last_byte) begin
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

    // Committed frame and its handshake; ack+commit together keeps frame_valid high
    always_ff @(posedge clk) begin
        if (rst) begin
            DATA        <= '0;
            FILTER      <= '0;
            frame_valid <= 1'b0;
        end else if (commit) begin
            DATA        <= shadow_data;
            FILTER      <= shadow_filt;
            frame_valid <= 1'b1;
        end else if (frame_ack && frame_valid) begin
            frame_valid <= 1'b0;
        end
    end

endmodule
